// File: rtl/pixel_fifo_pkg.sv
// Shared width helpers for the pixel FIFO and the line-buffer controller.
package pixel_fifo_pkg;

    // Bits in one pixel: every channel sample packed side by side.
    function automatic int unsigned pixel_width(input int unsigned data_width,
                                                input int unsigned in_channel);
        return data_width * in_channel;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so occupancy can represent DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel FIFO storage: simple dual-port, synchronous write, asynchronous read.
module pixel_fifo_mem
    import pixel_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 256,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // No reset on the array so it maps onto distributed RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_fifo.sv
// First-word fall-through pixel FIFO between an upstream layer and the line-buffer controller.
// Optional sticky overflow/underflow outputs are built when PIXEL_FIFO_ERR_FLAGS_EN is defined.
module pixel_fifo
    import pixel_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned IN_CHANNEL  = 16,
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned AF_MARGIN   = 4,
    localparam int unsigned PIXEL_WIDTH = pixel_width(DATA_WIDTH, IN_CHANNEL),
    localparam int unsigned PTR_WIDTH   = ptr_width(DEPTH),
    localparam int unsigned CNT_WIDTH   = cnt_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [PIXEL_WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    output logic [PIXEL_WIDTH-1:0] rd_data,
    output logic                   o_valid,
    output logic                   almost_full,
    output logic                   full,
    output logic [CNT_WIDTH-1:0]   count
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 push;
    logic                 pop;

    // Status decodes come only from the registered count.
    assign o_valid     = (count != '0);
    assign full        = (count == CNT_WIDTH'(DEPTH));
    assign almost_full = (count >= CNT_WIDTH'(DEPTH - AF_MARGIN));

    // A pop frees the head slot, so a full FIFO can accept a simultaneous push.
    assign pop  = rd_en & o_valid;
    assign push = wr_en & (~full | pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PIXEL_FIFO_ERR_FLAGS_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
            if (rd_en && !pop) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    pixel_fifo_mem #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pixel_fifo.sv
// Self-checking bench for pixel_fifo (DEPTH=16, AF_MARGIN=4) with a queue scoreboard.
module tb_pixel_fifo;

    localparam int unsigned PW    = 256;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [PW-1:0] wr_data;
    logic          rd_en;
    logic [PW-1:0] rd_data;
    logic          o_valid;
    logic          almost_full;
    logic          full;
    logic [CW-1:0] count;
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    pixel_fifo #(
        .DATA_WIDTH (16),
        .IN_CHANNEL (16),
        .DEPTH      (16),
        .AF_MARGIN  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .o_valid     (o_valid),
        .almost_full (almost_full),
        .full        (full),
        .count       (count)
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] q[$];
    logic          m_ovf;
    logic          m_udf;

    typedef struct {
        logic          w;
        logic          r;
        logic [PW-1:0] d;
        int            exp_cnt;
        logic          exp_valid;
        logic          exp_full;
        logic          exp_af;
        logic [PW-1:0] exp_head;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_pixel();
        logic [PW-1:0] r;
        for (int i = 0; i < PW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Compare DUT status against the reference queue.
    task automatic check_state(input string tag);
        int n;
        n = q.size();
        chk({tag, "_count"}, PW'(count), PW'(n));
        chk({tag, "_valid"}, PW'(o_valid), PW'(n != 0));
        chk({tag, "_full"}, PW'(full), PW'(n == DEPTH));
        chk({tag, "_af"}, PW'(almost_full), PW'(n >= 12));
        if (n != 0) begin
            chk({tag, "_head"}, rd_data, q[0]);
        end
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
        chk({tag, "_ovf"}, PW'(overflow), PW'(m_ovf));
        chk({tag, "_udf"}, PW'(underflow), PW'(m_udf));
`endif
    endtask

    // Drive one cycle from a negedge, score pops, then check at the next negedge.
    task automatic step(input logic w, input logic r, input logic [PW-1:0] d, input string tag);
        bit mpop;
        bit mpush;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        #1;
        mpop  = r && (q.size() != 0);
        mpush = w && ((q.size() != DEPTH) || mpop);
        if (mpop) begin
            chk({tag, "_pop"}, rd_data, q[0]);
            void'(q.pop_front());
        end
        if (w && !mpush) m_ovf = 1'b1;
        if (r && !mpop)  m_udf = 1'b1;
        if (mpush) q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("rst_count", PW'(count), PW'(0));
        chk("rst_valid", PW'(o_valid), PW'(0));
        chk("rst_full", PW'(full), PW'(0));
        chk("rst_af", PW'(almost_full), PW'(0));
    endtask

    initial begin
        int wprob;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        tbl[0] = '{1'b1, 1'b0, PW'(32'h11), 1, 1'b1, 1'b0, 1'b0, PW'(32'h11)};
        tbl[1] = '{1'b1, 1'b0, PW'(32'h22), 2, 1'b1, 1'b0, 1'b0, PW'(32'h11)};
        tbl[2] = '{1'b1, 1'b1, PW'(32'h33), 2, 1'b1, 1'b0, 1'b0, PW'(32'h22)};
        tbl[3] = '{1'b0, 1'b1, PW'(32'h00), 1, 1'b1, 1'b0, 1'b0, PW'(32'h33)};
        tbl[4] = '{1'b0, 1'b1, PW'(32'h00), 0, 1'b0, 1'b0, 1'b0, PW'(32'h00)};
        tbl[5] = '{1'b0, 1'b1, PW'(32'h00), 0, 1'b0, 1'b0, 1'b0, PW'(32'h00)};
        tbl[6] = '{1'b1, 1'b1, PW'(32'h44), 1, 1'b1, 1'b0, 1'b0, PW'(32'h44)};
        tbl[7] = '{1'b0, 1'b0, PW'(32'h00), 1, 1'b1, 1'b0, 1'b0, PW'(32'h44)};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d, "tbl");
            chk("tbl_exp_count", PW'(count), PW'(tbl[i].exp_cnt));
            chk("tbl_exp_valid", PW'(o_valid), PW'(tbl[i].exp_valid));
            chk("tbl_exp_full", PW'(full), PW'(tbl[i].exp_full));
            chk("tbl_exp_af", PW'(almost_full), PW'(tbl[i].exp_af));
            if (tbl[i].exp_valid) chk("tbl_exp_head", rd_data, tbl[i].exp_head);
        end

        // Fill to almost-full, then past full.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, PW'(i), "fill");
            if (i == 11) chk("af_before_12", PW'(almost_full), PW'(0));
        end
        chk("af_at_12", PW'(almost_full), PW'(1));
        chk("full_at_12", PW'(full), PW'(0));
        chk("count_at_12", PW'(count), PW'(12));
        chk("head_at_12", rd_data, PW'(1));
        for (int i = 13; i <= 17; i++) begin
            step(1'b1, 1'b0, PW'(i), "over");
            if (i == 16) chk("full_at_16", PW'(full), PW'(1));
        end
        chk("count_after_17", PW'(count), PW'(16));
        chk("head_after_17", rd_data, PW'(1));
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
        chk("overflow_set", PW'(overflow), PW'(1));
`endif

        // Simultaneous push/pop at full across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, PW'(32'h100 + i), "fullrw");
            chk("fullrw_count16", PW'(count), PW'(16));
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 0) chk("drain_first", rd_data, PW'(32'h104));
            step(1'b0, 1'b1, '0, "drain");
        end
        chk("drain_empty", PW'(o_valid), PW'(0));

        // Push and pop together on an empty FIFO.
        do_reset();
        step(1'b1, 1'b1, PW'(32'hAA), "empty_rw");
        chk("empty_rw_count", PW'(count), PW'(1));
        chk("empty_rw_valid", PW'(o_valid), PW'(1));
        chk("empty_rw_data", rd_data, PW'(32'hAA));
`ifdef PIXEL_FIFO_ERR_FLAGS_EN
        chk("underflow_set", PW'(underflow), PW'(1));
`endif

        // Asynchronous reset mid-cycle with 9 entries.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, PW'(32'h200 + i), "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", PW'(count), PW'(0));
        chk("arst_valid", PW'(o_valid), PW'(0));
        chk("arst_full", PW'(full), PW'(0));
        chk("arst_af", PW'(almost_full), PW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        step(1'b1, 1'b0, PW'(32'h55), "post_rst");
        chk("post_rst_head", rd_data, PW'(32'h55));

        // Random traffic against the reference queue.
        do_reset();
        wprob = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) wprob = (wprob == 30) ? 75 : 30;
            step(($urandom_range(0, 99) < wprob), ($urandom_range(0, 99) < 50), rand_pixel(), "rand");
            chk("rand_count_le_depth", PW'(count <= CW'(DEPTH)), PW'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bits per channel sample.
REQ-002 SHALL have parameter IN_CHANNEL, default 16, meaning channels per pixel; PIXEL_WIDTH = DATA_WIDTH*IN_CHANNEL.
REQ-003 SHALL have parameter DEPTH, default 16, meaning entries; power of two, at least 4.
REQ-004 SHALL have parameter AF_MARGIN, default 4, meaning free entries remaining when almost_full asserts; 1 <= AF_MARGIN < DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1 bit: push request from the upstream layer.
REQ-008 SHALL have port wr_data, input, PIXEL_WIDTH bits: pixel to push.
REQ-009 SHALL have port rd_en, input, 1 bit: pop request, driven by the downstream line-buffer controller (its fifo_rd_en).
REQ-010 SHALL have port rd_data, output, PIXEL_WIDTH bits: head entry (first-word fall-through).
REQ-011 SHALL have port o_valid, output, 1 bit: FIFO non-empty; feeds the controller's i_valid.
REQ-012 SHALL have port almost_full, output, 1 bit: count >= DEPTH-AF_MARGIN; feeds the controller's fifo_almost_full.
REQ-013 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 Push accepted iff wr_en & (~full | rd_en_accepted); data written at wr_ptr, wr_ptr increments.
REQ-016 Pop accepted iff rd_en & o_valid; rd_ptr increments.
REQ-017 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits each and wrap DEPTH-1 -> 0 without extra logic.
REQ-018 count: +1 on push only; -1 on pop only; unchanged on both or neither.
REQ-019 Full with wr_en and rd_en both high: pop and push both accepted; count stays DEPTH.
REQ-020 Empty with wr_en and rd_en both high: push accepted, pop ignored; count becomes 1.
REQ-021 wr_en while full without rd_en: write dropped, memory and pointers unchanged.
REQ-022 rd_en while empty: ignored, pointers unchanged.
REQ-023 Latency: a pixel pushed at edge k SHALL appear on rd_data with o_valid=1 immediately after edge k (one cycle write-to-read).
REQ-024 rd_data SHALL equal mem[rd_ptr] combinationally and hold stable while o_valid=1 and no pop occurs.
REQ-025 o_valid, full and almost_full SHALL be decoded combinationally from registered count, with no comb path from wr_en or rd_en.

Reset
REQ-026 On rst_n low: wr_ptr=0, rd_ptr=0, count=0, so o_valid=0, full=0, almost_full=0.
REQ-027 Reset mid-operation SHALL discard all contents; memory array is not reset and rd_data is don't-care while o_valid=0.

Configuration
REQ-028 With macro PIXEL_FIFO_ERR_FLAGS_EN defined: extra outputs overflow and underflow (1 bit each), sticky, set by a dropped write (REQ-021) or ignored read (REQ-022, REQ-020 pop side), cleared only by reset.
REQ-029 Without PIXEL_FIFO_ERR_FLAGS_EN: those ports and their logic are absent; behaviour is otherwise identical.

Structure
REQ-030 A shared package SHALL hold the PIXEL_WIDTH derivation and a clog2-based pointer/count width helper, used by this block and the line-buffer controller.
REQ-031 Storage SHALL be the sub-module pixel_fifo_mem: simple dual-port, synchronous write, asynchronous read, inferable as distributed RAM. Pointers, count and flags stay in pixel_fifo.

Verification (DEPTH=16, AF_MARGIN=4)
REQ-032 Push 12 pixels 0x1..0xC with no reads -> almost_full rises after the 12th edge, full=0, count=12, rd_data=0x1.
REQ-033 Push 17 pixels with no reads -> full after 16th, 17th dropped, count=16; with the error-flags macro, overflow=1.
REQ-034 From full, push and pop in the same cycle for 20 cycles -> count stays 16; popped sequence is in order with no loss across pointer wrap.
REQ-035 Empty FIFO, wr_en=rd_en=1 for one cycle with 0xAA -> count=1, o_valid=1, rd_data=0xAA; with the macro, underflow=1.
REQ-036 Fill to 9, assert rst_n low mid-cycle -> o_valid, full, almost_full and count drop to 0 asynchronously; the next push is read back first.
REQ-037 Random push/pop for 10k cycles against a reference queue -> data order matches and count never exceeds 16.
